// File: rtl/step_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_sequencer_pkg
// Description : State encodings, minimum step period and the full-step coil
//               pattern table shared by the step sequencer files.
// Revision    : 1.0 - initial release
// ============================================================================
package step_sequencer_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam int unsigned c_MIN_PERIOD = 2;

    // Two adjacent coils energised at a time (two-phase full step).
    function automatic logic [3:0] coil_pattern(input logic [1:0] phase);
        logic [3:0] pat;
        pat = 4'b0011;
        case (phase)
            2'd0: pat = 4'b0011;
            2'd1: pat = 4'b0110;
            2'd2: pat = 4'b1100;
            2'd3: pat = 4'b1001;
            default: pat = 4'b0011;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Loadable step-rate divider producing a one-cycle clock enable
//               every `period` enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int PER_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    output logic             tick
);

    logic [PER_W-1:0] r_count;
    logic             w_last;

    // period is guaranteed >= 2 by the caller, so period-1 never underflows.
    assign w_last = (r_count == (period - PER_W'(1)));
    assign tick   = enable & w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_last ? '0 : (r_count + PER_W'(1));
        end
    end

endmodule
`default_nettype wire

// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : step_sequencer
// Description : Stepper-motor move controller: accepts one move command and
//               steps a full-step coil sequence at a divided tick rate.
// Revision    : 1.0 - initial release
// ============================================================================
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int PER_W = 26,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic             abort,
    output logic [3:0]       coils,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    logic [1:0]       r_state;
    logic [1:0]       r_phase;
    logic             r_dir;
    logic [PER_W-1:0] r_period;
    logic [3:0]       r_coils;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;
    logic [CNT_W-1:0] r_steps_left;

    logic             w_accept;
    logic             w_run;
    logic             w_tick;
    logic [PER_W-1:0] w_period_eff;
    logic [1:0]       w_phase_next;

    assign w_accept     = cmd_valid & r_ready;
    assign w_run        = (r_state == c_ST_RUN);
    assign w_period_eff = (cmd_period < PER_W'(c_MIN_PERIOD)) ? PER_W'(c_MIN_PERIOD) : cmd_period;
    assign w_phase_next = r_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);

    tick_gen #(
        .PER_W (PER_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_accept),
        .enable (w_run),
        .period (r_period),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_phase      <= 2'd0;
            r_dir        <= 1'b0;
            r_period     <= PER_W'(c_MIN_PERIOD);
            r_coils      <= 4'b0000;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b1;
            r_steps_left <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_dir        <= cmd_dir;
                        r_period     <= w_period_eff;
                        r_coils      <= coil_pattern(r_phase);
                        r_steps_left <= cmd_steps;
                        r_ready      <= 1'b0;
                        if (cmd_steps == '0) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                c_ST_RUN: begin
                    // Abort takes priority over a coincident tick: no step is taken.
                    if (abort) begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_tick) begin
                        r_phase      <= w_phase_next;
                        r_coils      <= coil_pattern(w_phase_next);
                        r_steps_left <= r_steps_left - CNT_W'(1);
                        if (r_steps_left == CNT_W'(1)) begin
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign coils      = r_coils;
    assign busy       = r_busy;
    assign done       = r_done;
    assign steps_left = r_steps_left;

endmodule
`default_nettype wire
